// File: rtl/hline_move_ctrl.sv
// hline_move_ctrl: sequencer for the horizontal-line Y counter chain.
// Converts frame ticks and user requests into counter strobes.
//
// Ports:
//   clk, reset   clock and asynchronous active-high reset
//   frame        one-cycle tick per video frame
//   start, stop  level requests; stop wins over start
//   load_req     one-cycle request to load the counter from switches
//   speed        counter steps issued per frame (0 = frozen)
//   ycoord       current counter Q (fed back from the line counter)
//   up_o, dw_o   one-cycle increment / decrement strobes
//   ld_o         one-cycle load strobe
//   dir          1 = increasing Y, 0 = decreasing Y
//   moving       high while running or stepping
//   bounce_cnt   saturating count of direction reversals
//   overrun      sticky: frame arrived while still stepping
module hline_move_ctrl #(
    parameter int unsigned TOP_LIMIT = 18,
    parameter int unsigned BOT_LIMIT = 630,
    parameter int unsigned SPD_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame,
    input  logic             start,
    input  logic             stop,
    input  logic             load_req,
    input  logic [SPD_W-1:0] speed,
    input  logic [15:0]      ycoord,
    output logic             up_o,
    output logic             dw_o,
    output logic             ld_o,
    output logic             dir,
    output logic             moving,
    output logic [7:0]       bounce_cnt,
    output logic             overrun
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_STEP
    } state_t;

    localparam logic [SPD_W-1:0] CNT_ONE = {{(SPD_W-1){1'b0}}, 1'b1};
    localparam logic [SPD_W-1:0] CNT_ZERO = '0;

    state_t           r_state;
    logic [SPD_W-1:0] r_cnt;

    logic [16:0] w_y_up;
    logic [16:0] w_y_eff;
    logic        w_at_bot;
    logic        w_at_top;
    logic        w_hit;
    logic        w_last;

    // A strobe that is high now is applied by the counter at the end of
    // this cycle, so ycoord still shows the old value.  The limit check
    // therefore looks at the position the counter is about to reach;
    // otherwise back-to-back strobes could carry the line past a limit.
    assign w_y_up  = {1'b0, ycoord} + {16'd0, up_o};
    assign w_y_eff = (dw_o && (ycoord != 16'd0)) ?
                     (w_y_up - 17'd1) : w_y_up;

    assign w_at_bot = (w_y_eff >= 17'(BOT_LIMIT));
    assign w_at_top = (w_y_eff <= 17'(TOP_LIMIT));

    // Limit reached in the current direction: reverse instead of moving.
    assign w_hit  = dir ? w_at_bot : w_at_top;
    assign w_last = (r_cnt == CNT_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= CNT_ZERO;
            up_o       <= 1'b0;
            dw_o       <= 1'b0;
            ld_o       <= 1'b0;
            dir        <= 1'b1;
            moving     <= 1'b0;
            bounce_cnt <= 8'd0;
            overrun    <= 1'b0;
        end else begin
            // Strobes are single-cycle pulses by default.
            up_o <= 1'b0;
            dw_o <= 1'b0;
            ld_o <= 1'b0;

            if (frame && (r_state == S_STEP)) begin
                overrun <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (load_req) begin
                        r_state <= S_LOAD;
                        ld_o    <= 1'b1;
                        moving  <= 1'b0;
                    end else if (start && !stop) begin
                        r_state <= S_RUN;
                        moving  <= 1'b1;
                    end else begin
                        moving  <= 1'b0;
                    end
                end

                // ld_o is high for exactly this one cycle.
                S_LOAD: begin
                    r_state <= S_IDLE;
                    moving  <= 1'b0;
                end

                S_RUN: begin
                    if (load_req) begin
                        r_state <= S_LOAD;
                        ld_o    <= 1'b1;
                        moving  <= 1'b0;
                    end else if (stop) begin
                        r_state <= S_IDLE;
                        moving  <= 1'b0;
                    end else if (frame && (speed != CNT_ZERO)) begin
                        r_state <= S_STEP;
                        r_cnt   <= speed;
                        moving  <= 1'b1;
                    end else begin
                        moving  <= 1'b1;
                    end
                end

                S_STEP: begin
                    if (load_req) begin
                        r_state <= S_LOAD;
                        r_cnt   <= CNT_ZERO;
                        ld_o    <= 1'b1;
                        moving  <= 1'b0;
                    end else if (stop) begin
                        // Remaining steps are dropped.
                        r_state <= S_IDLE;
                        r_cnt   <= CNT_ZERO;
                        moving  <= 1'b0;
                    end else begin
                        r_cnt  <= r_cnt - CNT_ONE;
                        moving <= 1'b1;
                        if (w_last) begin
                            r_state <= S_RUN;
                        end
                        // A reversal consumes the step without a strobe.
                        if (w_hit) begin
                            dir <= ~dir;
                            if (bounce_cnt != 8'hFF) begin
                                bounce_cnt <= bounce_cnt + 8'd1;
                            end
                        end else begin
                            up_o <= dir;
                            dw_o <= ~dir;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= CNT_ZERO;
                    moving  <= 1'b0;
                end
            endcase
        end
    end

endmodule
